// File: rtl/add64_issue_ctrl.sv
// ----------------------------------------------------------------------------
// add64_issue_ctrl
//
// Issue and result stage wrapped around an external 64-bit carry-look-ahead
// adder. Operand beats are taken on a valid/ready handshake into an issue
// register (stage 1), which drives the adder inputs. The adder's sum/carry
// come back combinationally and are captured into a result register
// (stage 2), which is emitted on a second valid/ready handshake.
// A 64-bit accumulator lets the adder produce running sums (ACC / CLR ops).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   stage can accept a beat
//   in_a       operand A
//   in_b       operand B
//   in_op      00 ADD, 01 SUB, 10 ACC, 11 CLR
//   add_dina   to adder dina
//   add_dinb   to adder dinb
//   add_cin    to adder cin
//   add_sum    from adder sum (combinational return)
//   add_cout   from adder cout
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   out_sum    registered result
//   out_cout   registered carry-out (SUB: 1 = no borrow)
//   out_ovf    registered signed overflow
//   acc_q      current accumulator
// ----------------------------------------------------------------------------
module add64_issue_ctrl #(
   parameter int                DATA_W  = 64,   // must stay 64 to match the adder
   parameter logic [DATA_W-1:0] ACC_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [1:0]        in_op,
   output logic [DATA_W-1:0] add_dina,
   output logic [DATA_W-1:0] add_dinb,
   output logic              add_cin,
   input  logic [DATA_W-1:0] add_sum,
   input  logic              add_cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_cout,
   output logic              out_ovf,
   output logic [DATA_W-1:0] acc_q
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   localparam int MSB = DATA_W - 1;

   // Stage 1: issue register
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic [1:0]        s1_op_q, s1_op_d;

   // Stage 2: result register
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_sum_q, out_sum_d;
   logic              out_cout_q, out_cout_d;
   logic              out_ovf_q, out_ovf_d;

   logic [DATA_W-1:0] acc_d;

   logic s1_adv;
   logic accept;
   logic ovf;

   // Stage 1 moves into stage 2 whenever stage 2 is empty or being drained
   // this cycle. in_ready is combinational from out_ready: there is no skid
   // buffer, so a full pipe frees a slot only in the cycle it advances.
   assign s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s1_adv;
   assign accept   = in_valid & in_ready;

   // Adder drive comes only from registered state, never from in_* directly,
   // so the adder path starts at a flop.
   // NOTE: every signal assigned in an always_comb gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      add_dina = '0;
      add_dinb = '0;
      add_cin  = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            add_dina = s1_a_q;
            add_dinb = s1_b_q;
         end
         OP_SUB: begin
            // a - b as a + ~b + 1, so carry-out 1 means no borrow
            add_dina = s1_a_q;
            add_dinb = ~s1_b_q;
            add_cin  = 1'b1;
         end
         OP_ACC: begin
            add_dina = acc_q;
            add_dinb = s1_a_q;
         end
         default: ;  // OP_CLR: drive zeros so the emitted result is 0/0/0
      endcase
   end

   // Signed overflow from the operands actually presented to the adder, which
   // covers SUB correctly because dinb is already inverted.
   assign ovf = (add_dina[MSB] == add_dinb[MSB]) & (add_sum[MSB] != add_dina[MSB]);

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_ovf_d   = out_ovf_q;
      acc_d       = acc_q;

      // A new beat may overwrite stage 1 in the same edge the old one leaves.
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_op_d    = in_op;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         out_valid_d = 1'b1;
         out_sum_d   = add_sum;
         out_cout_d  = add_cout;
         out_ovf_d   = ovf;
         // The accumulator changes at the same edge the beat leaves stage 1,
         // so a following ACC beat already sees the new value.
         if (s1_op_q == OP_ACC) begin
            acc_d = add_sum;
         end else if (s1_op_q == OP_CLR) begin
            acc_d = '0;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= OP_ADD;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         acc_q       <= ACC_RST;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_add64_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_add64_issue_ctrl
//
// Bench for add64_issue_ctrl. The 64-bit adder is modelled behaviourally
// here. A monitor turns every accepted input beat into an expected result
// (plain arithmetic on a + b, a - b, acc + a) queued in acceptance order, and
// compares each emitted result against the head of that queue. Directed
// vectors, multi-cycle sequences and random traffic all run through it.
// ----------------------------------------------------------------------------
module tb_add64_issue_ctrl;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;
   localparam logic [63:0] ACC_RST = 64'h0;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic [1:0]  in_op;
   logic [63:0] add_dina;
   logic [63:0] add_dinb;
   logic        add_cin;
   logic [63:0] add_sum;
   logic        add_cout;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic [63:0] acc_q;

   add64_issue_ctrl #(.DATA_W(64), .ACC_RST(ACC_RST)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .add_dina  (add_dina),
      .add_dinb  (add_dinb),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .acc_q     (acc_q)
   );

   // Behavioural stand-in for the carry-look-ahead adder
   assign {add_cout, add_sum} = {1'b0, add_dina} + {1'b0, add_dinb} + {64'd0, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t        exp_q[$];
   logic [63:0] m_acc = ACC_RST;
   int          n_out = 0;
   bit          acc_seen;
   bit          out_seen;

   function automatic void model_beat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      res_t        r;
      logic [64:0] w;
      case (op)
         OP_ADD: begin
            w      = {1'b0, a} + {1'b0, b};
            r.sum  = w[63:0];
            r.cout = w[64];
            r.ovf  = (a[63] == b[63]) && (r.sum[63] != a[63]);
         end
         OP_SUB: begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[63] != b[63]) && (r.sum[63] != a[63]);
         end
         OP_ACC: begin
            w      = {1'b0, m_acc} + {1'b0, a};
            r.sum  = w[63:0];
            r.cout = w[64];
            r.ovf  = (m_acc[63] == a[63]) && (r.sum[63] != m_acc[63]);
            m_acc  = r.sum;
         end
         default: begin
            r.sum  = '0;
            r.cout = 1'b0;
            r.ovf  = 1'b0;
            m_acc  = '0;
         end
      endcase
      exp_q.push_back(r);
   endfunction

   // Called in the low clock phase: looks at what the coming edge will do.
   task automatic observe();
      res_t r;
      acc_seen = 1'b0;
      out_seen = 1'b0;
      if (rst) begin
         exp_q.delete();
         m_acc = ACC_RST;
      end else begin
         if (out_valid && out_ready) begin
            out_seen = 1'b1;
            n_out++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_out actual=out_valid=1 expected=no pending beat (sum=%h)", out_sum);
            end else begin
               r = exp_q.pop_front();
               check("mon_sum", out_sum, r.sum);
               check("mon_cout", {63'd0, out_cout}, {63'd0, r.cout});
               check("mon_ovf", {63'd0, out_ovf}, {63'd0, r.ovf});
            end
         end
         if (in_valid && in_ready) begin
            acc_seen = 1'b1;
            model_beat(in_op, in_a, in_b);
         end
      end
   endtask

   // Inputs are changed right after a falling edge; one call = one rising edge.
   task automatic tick();
      #1;
      observe();
      @(negedge clk);
   endtask

   function automatic logic [63:0] rand64();
      case ($urandom_range(0, 5))
         0:       return 64'h0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic [63:0] acc;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [63:0] held;
      int          idx;
      int          base;

      vecs[0] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b1, 1'b0, 64'd0};
      vecs[1] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'd0};
      vecs[2] = '{OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64'd0};
      vecs[3] = '{OP_SUB, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0, 64'd0};
      vecs[4] = '{OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'd0};
      vecs[5] = '{OP_ACC, 64'd10, 64'hDEAD, 64'd10, 1'b0, 1'b0, 64'd10};
      vecs[6] = '{OP_ACC, 64'd20, 64'hBEEF, 64'd30, 1'b0, 1'b0, 64'd30};
      vecs[7] = '{OP_ACC, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'hE, 1'b1, 1'b0, 64'hE};
      vecs[8] = '{OP_CLR, 64'd99, 64'd99, 64'd0, 1'b0, 1'b0, 64'd0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = OP_ADD;
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_sum", out_sum, 64'd0);
      check("rst_acc", acc_q, ACC_RST);
      check("rst_dina", add_dina, 64'd0);

      // table: one beat at a time, result expected one edge after acceptance
      foreach (vecs[i]) begin
         in_valid = 1'b1;
         in_op    = vecs[i].op;
         in_a     = vecs[i].a;
         in_b     = vecs[i].b;
         tick();
         in_valid = 1'b0;
         tick();
         check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
         check($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), {63'd0, out_cout}, {63'd0, vecs[i].cout});
         check($sformatf("vec%0d_ovf", i), {63'd0, out_ovf}, {63'd0, vecs[i].ovf});
         check($sformatf("vec%0d_acc", i), acc_q, vecs[i].acc);
      end
      tick();

      // back-to-back ACC at full throughput, then CLR
      in_valid = 1'b1;
      in_op    = OP_ACC;
      in_a     = 64'd10;
      tick();
      in_a = 64'd20;
      tick();
      check("b2b_sum0", out_sum, 64'd10);
      check("b2b_ready0", {63'd0, in_ready}, 64'd1);
      in_a = 64'd30;
      tick();
      check("b2b_sum1", out_sum, 64'd30);
      check("b2b_ready1", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      tick();
      check("b2b_sum2", out_sum, 64'd60);
      check("b2b_valid2", {63'd0, out_valid}, 64'd1);
      check("b2b_acc", acc_q, 64'd60);
      in_valid = 1'b1;
      in_op    = OP_CLR;
      tick();
      in_valid = 1'b0;
      tick();
      check("clr_sum", out_sum, 64'd0);
      check("clr_acc", acc_q, 64'd0);
      tick();

      // backpressure: 4 ADD beats, out_ready low for the first 3 edges
      idx  = 0;
      base = n_out;
      for (int c = 0; c < 12; c++) begin
         out_ready = (c >= 3);
         in_valid  = (idx < 4);
         in_op     = OP_ADD;
         in_a      = 64'h100 * 64'(idx + 1);
         in_b      = 64'(idx + 1);
         tick();
         if (acc_seen) idx++;
         if (c == 1) begin
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            held = out_sum;
         end
         if (c == 2) begin
            check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
            check("bp_stall_sum", out_sum, 64'h101);
            check("bp_stall_stable", out_sum, held);
         end
      end
      in_valid = 1'b0;
      check("bp_count", 64'(n_out - base), 64'd4);
      check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = OP_ACC;
      in_a      = 64'd5;
      tick();
      in_op = OP_ADD;
      in_a  = 64'd1;
      in_b  = 64'd1;
      tick();
      in_valid = 1'b0;
      check("mid_full_valid", {63'd0, out_valid}, 64'd1);
      check("mid_full_ready", {63'd0, in_ready}, 64'd0);
      check("mid_full_acc", acc_q, 64'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_acc", acc_q, ACC_RST);
      check("mid_rst_sum", out_sum, 64'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("mid_no_stale", {63'd0, out_valid}, 64'd0);
      end

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_op     = 2'($urandom_range(0, 3));
         in_a      = rand64();
         in_b      = rand64();
         tick();
      end

      // drain, bounded
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
      tick();
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      check("drain_valid", {63'd0, out_valid}, 64'd0);
      check("final_acc", acc_q, m_acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
